// File: rtl/amiga_kbd_tx.sv
// amiga_kbd_tx -- Amiga keyboard-side serial transmitter.
//
// Queues make/break key events from the keymap path and shifts them out
// on the KDAT/KCLK keyboard bus towards CIA-A SP/CNT. After reset it sends
// the power-up codes 0xFD and 0xFE. Each byte waits for the CIA handshake.
// If no handshake arrives in time, it sends single-bit resync pulses until
// one does, and then sends 0xF9 followed by the lost byte.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   key_code    in   [6:0] Amiga raw key code (7'h7f = unmapped, ignored)
//   key_up      in   1 = release (break), 0 = press (make)
//   key_strobe  in   one-cycle pulse that enqueues {key_code, key_up}
//   fifo_full   out  event FIFO full; strobes while full are dropped
//   busy        out  transmitter active or FIFO non-empty
//   kdat_o      out  KDAT drive, 0 = pull low, 1 = release
//   kclk_o      out  KCLK drive, 0 = pull low, 1 = release
//   kdat_i      in   KDAT bus level (wired-AND with CIA SP)
module amiga_kbd_tx #(
    parameter int unsigned CLK_HZ    = 28_000_000,
    parameter int unsigned FIFO_LOG2 = 3,
    parameter int unsigned HS_MIN    = CLK_HZ / 1_000_000,
    parameter int unsigned TMO       = CLK_HZ / 1000 * 143,
    parameter bit          POWERUP   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] key_code,
    input  logic       key_up,
    input  logic       key_strobe,
    output logic       fifo_full,
    output logic       busy,
    output logic       kdat_o,
    output logic       kclk_o,
    input  logic       kdat_i
);

    localparam int unsigned T20   = CLK_HZ / 50_000;
    localparam int unsigned DEPTH = 1 << FIFO_LOG2;
    localparam int unsigned TW    = (T20 > 1) ? $clog2(T20) : 1;
    localparam int unsigned HW    = $clog2(HS_MIN + 1);
    localparam int unsigned OW    = $clog2(TMO + 1);

    localparam logic [TW-1:0] T20_LAST = TW'(T20 - 1);
    localparam logic [HW-1:0] HS_LAST  = HW'(HS_MIN - 1);
    localparam logic [OW-1:0] TMO_LAST = OW'(TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CLKLO,
        S_CLKHI,
        S_HS_WAIT,
        S_HS_END
    } state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [7:0]           shift_q, shift_d;
    logic [3:0]           bits_q, bits_d;
    logic [7:0]           retry_q, retry_d;
    logic [1:0]           pu_q, pu_d;          // 0: FD next, 1: FE next, 2: done
    logic                 f9_pend_q, f9_pend_d;
    logic                 rt_pend_q, rt_pend_d;
    logic                 resync_q, resync_d;
    logic [HW-1:0]        hs_q, hs_d;
    logic [OW-1:0]        tmo_q, tmo_d;
    logic [1:0]           sync_q;
    logic                 kdat_q, kdat_d;
    logic                 kclk_q, kclk_d;

    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_LOG2:0]   wr_ptr_q, rd_ptr_q;
    logic                 empty, full, push, pop, load;
    logic [7:0]           load_byte, head;
    logic                 kdat_s;

    assign kdat_s = sync_q[1];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                    (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
    assign head   = mem_q[rd_ptr_q[FIFO_LOG2-1:0]];

    assign fifo_full = full;
    assign busy      = (state_q != S_IDLE) || !empty;
    assign kdat_o    = kdat_q;
    assign kclk_o    = kclk_q;

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        shift_d   = shift_q;
        bits_d    = bits_q;
        retry_d   = retry_q;
        pu_d      = pu_q;
        f9_pend_d = f9_pend_q;
        rt_pend_d = rt_pend_q;
        resync_d  = resync_q;
        hs_d      = hs_q;
        tmo_d     = tmo_q;
        pop       = 1'b0;
        load      = 1'b0;
        load_byte = '0;

        unique case (state_q)
            S_IDLE: begin
                // Recovery (F9 then the lost byte) goes before power-up codes
                // and queued events. F9 does not overwrite the retry register.
                if (f9_pend_q) begin
                    load      = 1'b1;
                    load_byte = 8'hF9;
                    f9_pend_d = 1'b0;
                end else if (rt_pend_q) begin
                    load      = 1'b1;
                    load_byte = retry_q;
                    rt_pend_d = 1'b0;
                end else if (pu_q == 2'd0) begin
                    load      = 1'b1;
                    load_byte = 8'hFD;
                    retry_d   = 8'hFD;
                    pu_d      = 2'd1;
                end else if (pu_q == 2'd1) begin
                    load      = 1'b1;
                    load_byte = 8'hFE;
                    retry_d   = 8'hFE;
                    pu_d      = 2'd2;
                end else if (!empty) begin
                    load      = 1'b1;
                    pop       = 1'b1;
                    load_byte = head;
                    retry_d   = head;
                end
                if (load) begin
                    shift_d = load_byte;
                    bits_d  = 4'd8;
                    tmr_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (tmr_q == T20_LAST) begin
                    tmr_d   = '0;
                    state_d = S_CLKLO;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_CLKLO: begin
                if (tmr_q == T20_LAST) begin
                    tmr_d   = '0;
                    state_d = S_CLKHI;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_CLKHI: begin
                if (tmr_q == T20_LAST) begin
                    tmr_d = '0;
                    if (bits_q == 4'd1) begin
                        tmo_d   = '0;
                        hs_d    = '0;
                        state_d = S_HS_WAIT;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                        bits_d  = bits_q - 4'd1;
                        state_d = S_SETUP;
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_HS_WAIT: begin
                hs_d = kdat_s ? '0 : hs_q + HW'(1);
                if (!kdat_s && hs_q == HS_LAST) begin
                    state_d = S_HS_END;
                end else if (tmo_q == TMO_LAST) begin
                    // Lost sync: clock out a single '1' bit, then wait again.
                    shift_d  = 8'h80;
                    bits_d   = 4'd1;
                    tmr_d    = '0;
                    resync_d = 1'b1;
                    state_d  = S_SETUP;
                end else begin
                    tmo_d = tmo_q + OW'(1);
                end
            end
            S_HS_END: begin
                if (kdat_s) begin
                    state_d = S_IDLE;
                    if (resync_q) begin
                        f9_pend_d = 1'b1;
                        rt_pend_d = 1'b1;
                        resync_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Dequeue has priority, so a pop frees the slot that this push uses.
        push = key_strobe && (key_code != 7'h7f) && (!full || pop);

        kclk_d = (state_d != S_CLKLO);
        kdat_d = (state_d == S_SETUP || state_d == S_CLKLO || state_d == S_CLKHI)
                 ? ~shift_d[7] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            shift_q   <= '0;
            bits_q    <= '0;
            retry_q   <= '0;
            pu_q      <= POWERUP ? 2'd0 : 2'd2;
            f9_pend_q <= 1'b0;
            rt_pend_q <= 1'b0;
            resync_q  <= 1'b0;
            hs_q      <= '0;
            tmo_q     <= '0;
            sync_q    <= '1;
            kdat_q    <= 1'b1;
            kclk_q    <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            shift_q   <= shift_d;
            bits_q    <= bits_d;
            retry_q   <= retry_d;
            pu_q      <= pu_d;
            f9_pend_q <= f9_pend_d;
            rt_pend_q <= rt_pend_d;
            resync_q  <= resync_d;
            hs_q      <= hs_d;
            tmo_q     <= tmo_d;
            sync_q    <= {sync_q[0], kdat_i};
            kdat_q    <= kdat_d;
            kclk_q    <= kclk_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[FIFO_LOG2-1:0]] <= {key_code, key_up};
    end

endmodule

// File: tb/tb_amiga_kbd_tx.sv
module tb_amiga_kbd_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] key_code = '0;
    logic       key_up = 1'b0;
    logic       key_strobe = 1'b0;
    logic       fifo_full, busy, kdat_o, kclk_o;
    logic       cia_dat = 1'b1;
    logic       kdat_i;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned cyc = 0;

    assign kdat_i = kdat_o & cia_dat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // T20 = 20 cycles, handshake needs 4 low cycles, timeout 2000 cycles.
    amiga_kbd_tx #(
        .CLK_HZ   (1_000_000),
        .FIFO_LOG2(3),
        .HS_MIN   (4),
        .TMO      (2000),
        .POWERUP  (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_code  (key_code),
        .key_up    (key_up),
        .key_strobe(key_strobe),
        .fifo_full (fifo_full),
        .busy      (busy),
        .kdat_o    (kdat_o),
        .kclk_o    (kclk_o),
        .kdat_i    (kdat_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [6:0] c, input logic up);
        key_code   = c;
        key_up     = up;
        key_strobe = 1'b1;
        @(negedge clk);
        key_strobe = 1'b0;
    endtask

    // One KCLK pulse; the bit is taken where KCLK returns high.
    task automatic recv_bit(output logic b, output logic ok);
        int n;
        ok = 1'b1;
        b  = 1'b0;
        n  = 0;
        while (kclk_o == 1'b1 && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) begin ok = 1'b0; return; end
        n = 0;
        while (kclk_o == 1'b0 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin ok = 1'b0; return; end
        b = ~kdat_o;
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        logic       b, ok;
        v  = '0;
        ok = 1'b1;
        for (int i = 0; i < 8 && ok; i++) begin
            recv_bit(b, ok);
            v = {v[6:0], b};
        end
        chk({tag, " done"}, 32'(ok), 32'd1);
        chk(tag, 32'(v), 32'(exp));
    endtask

    task automatic handshake();
        repeat (25) @(negedge clk);
        cia_dat = 1'b0;
        repeat (85) @(negedge clk);
        cia_dat = 1'b1;
    endtask

    task automatic idle_watch(input string tag, input int cycles);
        int bad;
        bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (!kclk_o || !kdat_o) bad++;
        end
        chk({tag, " lines"}, 32'(bad), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic        b, ok;
        int unsigned t0, dt;
        int          drops, n;

        // Reset state and power-up codes
        repeat (4) @(negedge clk);
        chk("rst kdat", 32'(kdat_o), 32'd1);
        chk("rst kclk", 32'(kclk_o), 32'd1);
        chk("rst full", 32'(fifo_full), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("pu busy", 32'(busy), 32'd1);
        recv_byte("pu FD", 8'hFD);
        handshake();
        recv_byte("pu FE", 8'hFE);
        handshake();
        idle_watch("pu idle", 100);

        // Make code 0x20 -> byte 0x40
        strobe(7'h20, 1'b0);
        recv_byte("make 20", 8'h40);
        handshake();
        idle_watch("make idle", 50);

        // Unmapped code ignored
        strobe(7'h7f, 1'b0);
        idle_watch("unmapped", 50);

        // FIFO fill: 1 in shift register, then 8 queued
        strobe(7'h01, 1'b0);
        repeat (2) @(negedge clk);
        for (int c = 2; c <= 8; c++) strobe(7'(c), 1'b0);
        chk("fifo 7 full", 32'(fifo_full), 32'd0);
        strobe(7'h09, 1'b0);
        chk("fifo 8 full", 32'(fifo_full), 32'd1);
        strobe(7'h55, 1'b0);
        chk("fifo drop full", 32'(fifo_full), 32'd1);
        recv_byte("fifo b1", 8'h02);
        // Strobe held across the pop cycle: only that cycle's write may land
        repeat (25) @(negedge clk);
        cia_dat = 1'b0;
        repeat (85) @(negedge clk);
        key_code   = 7'h3A;
        key_up     = 1'b0;
        key_strobe = 1'b1;
        cia_dat    = 1'b1;
        drops = 0;
        repeat (12) begin
            @(negedge clk);
            if (!fifo_full) drops++;
        end
        key_strobe = 1'b0;
        chk("fifo full across pop", 32'(drops), 32'd0);
        for (int c = 2; c <= 9; c++) begin
            recv_byte("fifo bn", 8'(c << 1));
            handshake();
        end
        recv_byte("fifo simul", 8'h74);
        handshake();
        idle_watch("fifo idle", 600);

        // Lost handshake: resync bit, F9, then retransmission once
        strobe(7'h45, 1'b1);
        recv_byte("rs byte", 8'h8B);
        t0 = cyc;
        recv_bit(b, ok);
        dt = cyc - t0;
        chk("rs bit ok", 32'(ok), 32'd1);
        chk("rs bit val", 32'(b), 32'd1);
        chk("rs delay", 32'(dt >= 2030 && dt <= 2090), 32'd1);
        handshake();
        recv_byte("rs F9", 8'hF9);
        handshake();
        recv_byte("rs retry", 8'h8B);
        handshake();
        idle_watch("rs idle", 600);

        // Reset in the middle of a byte
        strobe(7'h10, 1'b0);
        strobe(7'h11, 1'b0);
        strobe(7'h12, 1'b0);
        for (int i = 0; i < 3; i++) recv_bit(b, ok);
        n = 0;
        while (kclk_o == 1'b1 && n < 200) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        chk("mid in clklo", 32'(kclk_o), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid rst kclk", 32'(kclk_o), 32'd1);
        chk("mid rst kdat", 32'(kdat_o), 32'd1);
        chk("mid rst full", 32'(fifo_full), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        recv_byte("mid FD", 8'hFD);
        handshake();
        recv_byte("mid FE", 8'hFE);
        handshake();
        idle_watch("mid idle", 600);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
